// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state type and constants for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic {IDLE, ISSUE} state_t;
  localparam int MEM_DEPTH_DEFAULT = 256;
  localparam logic PORT_PIPE = 1'b0;
  localparam logic PORT_DMA = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; on a tie the port not granted last wins
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);
  assign grant_valid = |eligible;
  assign grant_id = &eligible ? ~last_grant : eligible[1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port data memory (port 0 pipeline, port 1 DMA)
// Define DMEM_RANGE_CHECK_EN to reject addresses at or beyond MEM_DEPTH with err.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state_q, state_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, cmd_wdata_q, cmd_wdata_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d, win_addr;
  logic cmd_we_q, cmd_we_d, cmd_id_q, cmd_id_d, cmd_err_q, cmd_err_d;
  logic last_grant_q, last_grant_d;
  logic issue, grant_valid, grant_id, range_bad;
  logic [1:0] eligible;
  assign issue = state_q == ISSUE;
  // the port being served still shows req at its ack edge, so it sits this round out
  assign eligible = issue ? (cmd_id_q == PORT_DMA ? {1'b0, req0} : {req1, 1'b0}) : {req1, req0};
  rr_arb2 u_rr (
    .eligible    (eligible),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );
  assign win_addr = grant_id ? addr1 : addr0;
`ifdef DMEM_RANGE_CHECK_EN
  assign range_bad = 64'(win_addr) >= 64'(MEM_DEPTH);
`else
  logic unused_depth;
  assign unused_depth = MEM_DEPTH != 0;
  assign range_bad = 1'b0;
`endif
  always_comb begin
    state_d = grant_valid ? ISSUE : IDLE;
    ack0_d = issue && cmd_id_q == PORT_PIPE;
    ack1_d = issue && cmd_id_q == PORT_DMA;
    err_d = issue && cmd_err_q;
    rdata_d = !issue ? rdata_q : cmd_err_q ? '0 : cmd_we_q ? rdata_q : mem_rdata;
    cmd_addr_d = grant_valid ? win_addr : cmd_addr_q;
    cmd_wdata_d = grant_valid ? (grant_id ? wdata1 : wdata0) : cmd_wdata_q;
    cmd_we_d = grant_valid ? (grant_id ? we1 : we0) : cmd_we_q;
    cmd_id_d = grant_valid ? grant_id : cmd_id_q;
    cmd_err_d = grant_valid ? range_bad : cmd_err_q;
    last_grant_d = grant_valid ? grant_id : last_grant_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
      cmd_addr_q <= '0;
      cmd_wdata_q <= '0;
      cmd_we_q <= 1'b0;
      cmd_id_q <= 1'b0;
      cmd_err_q <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_we_q <= cmd_we_d;
      cmd_id_q <= cmd_id_d;
      cmd_err_q <= cmd_err_d;
      last_grant_q <= last_grant_d;
    end
  end
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign err = err_q;
  assign rdata = rdata_q;
  assign busy = issue;
  assign mem_addr = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign mem_we = issue && cmd_we_q && !cmd_err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a negedge-acting 256-word memory model
module tb_dmem_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, err, busy, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [256];
  bit mem_init = 1'b0;
  int total = 0, passed = 0, fails = 0;
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = i;
      mem_init = 1'b1;
    end
    mem_rdata = mem[mem_addr[7:0]];
    if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
  end
  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    #3;
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    #9 reset = 1'b0;
    step();
    req0 = 1'b1; addr0 = 5; we0 = 1'b0;
    step();
    chk("rd_busy", busy, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 5);
    chk("rd_ack0_early", ack0, 0);
    step();
    chk("rd_ack0", ack0, 1);
    chk("rd_ack1", ack1, 0);
    chk("rd_rdata", rdata, 5);
    chk("rd_err", err, 0);
    chk("rd_idle", busy, 0);
    req0 = 1'b0;
    step();
    chk("rd_ack0_pulse", ack0, 0);
    chk("rd_ack1_never", ack1, 0);
    req1 = 1'b1; addr1 = 10; wdata1 = 32'hDEADBEEF; we1 = 1'b1;
    chk("wr_we_before", mem_we, 0);
    step();
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 10);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    chk("wr_ack1", ack1, 1);
    chk("wr_we_after", mem_we, 0);
    chk("wr_rdata_hold", rdata, 5);
    we1 = 1'b0;
    step();
    chk("rb_busy", busy, 1);
    chk("rb_ack1_low", ack1, 0);
    chk("rb_we", mem_we, 0);
    step();
    chk("rb_ack1", ack1, 1);
    chk("rb_rdata", rdata, 32'hDEADBEEF);
    req1 = 1'b0;
    step();
    req0 = 1'b1; addr0 = 3; req1 = 1'b1; addr1 = 7;
    step();
    chk("sim_first_addr", mem_addr, 3);
    step();
    chk("sim_ack0", ack0, 1);
    chk("sim_ack1_low", ack1, 0);
    chk("sim_rdata0", rdata, 3);
    chk("sim_b2b_busy", busy, 1);
    chk("sim_second_addr", mem_addr, 7);
    req0 = 1'b0;
    step();
    chk("sim_ack1", ack1, 1);
    chk("sim_ack0_low", ack0, 0);
    chk("sim_rdata1", rdata, 7);
    req1 = 1'b0;
    step();
    req0 = 1'b1; addr0 = 20; req1 = 1'b1; addr1 = 21;
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("fair_ack0", ack0, (k % 2 == 0) ? 1 : 0);
      chk("fair_ack1", ack1, (k % 2 == 1) ? 1 : 0);
      chk("fair_rdata", rdata, (k % 2 == 0) ? 20 : 21);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("fair_tail_ack0", ack0, 1);
    step();
    chk("fair_drained", busy, 0);
    req0 = 1'b1; addr0 = 9;
    step();
    chk("mid_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack0", ack0, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    addr0 = 4; req1 = 1'b1; addr1 = 8;
    #1 reset = 1'b0;
    step();
    chk("post_rst_addr", mem_addr, 4);
    step();
    chk("post_rst_ack0", ack0, 1);
    chk("post_rst_rdata0", rdata, 4);
    req0 = 1'b0;
    step();
    chk("post_rst_ack1", ack1, 1);
    chk("post_rst_rdata1", rdata, 8);
    req1 = 1'b0;
    step();
`ifdef DMEM_RANGE_CHECK_EN
    req0 = 1'b1; addr0 = 300; wdata0 = 32'h1234; we0 = 1'b1;
    step();
    chk("rng_busy", busy, 1);
    chk("rng_mem_we", mem_we, 0);
    step();
    chk("rng_ack0", ack0, 1);
    chk("rng_err", err, 1);
    chk("rng_rdata", rdata, 0);
    addr0 = 44; we0 = 1'b0;
    step();
    chk("rng_rb_busy", busy, 1);
    step();
    chk("rng_rb_ack0", ack0, 1);
    chk("rng_rb_err", err, 0);
    chk("rng_rb_rdata", rdata, 44);
    req0 = 1'b0;
    step();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
